pingpong_frame_streamer: RTL and testbench

Downstream consumer of the ping-pong sample buffer. It waits for a buffer-ready pulse, then drains exactly DEPTH signed samples over the buffer's read valid/ready handshake. Each frame is serialized into a byte stream for the UART/host link: a header, then the samples LSB-first, then an optional checksum. The block sits between the ping-pong buffer and the byte-oriented transmitter.

---
 rtl/pingpong_frame_streamer.sv | 165 ++++++++++++++++
 tb/tb_pingpong_frame_streamer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_streamer.sv
// Drains one full ping-pong buffer per frame and serializes it as bytes: SYNC, frame number, samples LSB-first.
// Define STREAMER_CHECKSUM_EN to append an 8-bit modulo-256 sum of the payload bytes.
module pingpong_frame_streamer #(
    parameter int         WIDTH            = 36,
    parameter int         DEPTH            = 256,
    parameter logic [7:0] SYNC_BYTE        = 8'hA5,
    parameter int         ADDR_WIDTH       = $clog2(DEPTH),
    parameter int         BYTES_PER_SAMPLE = (WIDTH + 7) / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    buffer_ready_i,
    input  logic signed [WIDTH-1:0] read_data_i,
    input  logic                    read_valid_i,
    output logic                    read_ready_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    busy_o,
    output logic [ADDR_WIDTH:0]     sample_count_o,
    output logic [15:0]             frame_count_o,
    output logic                    frame_dropped_o
);

    localparam int SHIFT_W = BYTES_PER_SAMPLE * 8;
    localparam int IDX_W   = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam int CNT_W   = ADDR_WIDTH + 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(DEPTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR0  = 3'd1;
    localparam logic [2:0] HDR1  = 3'd2;
    localparam logic [2:0] FETCH = 3'd3;
    localparam logic [2:0] SEND  = 3'd4;
`ifdef STREAMER_CHECKSUM_EN
    localparam logic [2:0] CSUM  = 3'd5;
`endif

    logic [2:0]         state;
    logic [SHIFT_W-1:0] sample_ext;
    logic [SHIFT_W-1:0] shift_reg;
    logic [IDX_W-1:0]   byte_idx;
    logic               tx_hs;
    logic               rd_hs;
    logic               last_byte;
    logic               last_sample;
`ifdef STREAMER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    // Size cast of a signed operand sign-extends, filling the top of the last byte with the sign bit.
    assign sample_ext   = SHIFT_W'(read_data_i);

    assign read_ready_o = (state == FETCH);
    assign busy_o       = (state != IDLE);
    assign tx_hs        = tx_valid_o && tx_ready_i;
    assign rd_hs        = read_valid_i && read_ready_o;
    assign last_byte    = (byte_idx == LAST_IDX);
    assign last_sample  = (sample_count_o == LAST_SAMPLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            shift_reg       <= '0;
            byte_idx        <= '0;
            tx_data_o       <= '0;
            tx_valid_o      <= 1'b0;
            sample_count_o  <= '0;
            frame_count_o   <= '0;
            frame_dropped_o <= 1'b0;
`ifdef STREAMER_CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            // A start request is only honoured from IDLE; the final-handshake cycle still counts as busy.
            frame_dropped_o <= buffer_ready_i && busy_o;

            case (state)
                IDLE: begin
                    if (buffer_ready_i) begin
                        state          <= HDR0;
                        sample_count_o <= '0;
                        tx_data_o      <= SYNC_BYTE;
                        tx_valid_o     <= 1'b1;
`ifdef STREAMER_CHECKSUM_EN
                        csum           <= '0;
`endif
                    end
                end

                HDR0: begin
                    if (tx_hs) begin
                        state     <= HDR1;
                        tx_data_o <= frame_count_o[7:0];
                    end
                end

                HDR1: begin
                    if (tx_hs) begin
                        state      <= FETCH;
                        tx_valid_o <= 1'b0;
                    end
                end

                // shift_reg keeps only the bytes not yet presented on tx_data_o.
                FETCH: begin
                    if (rd_hs) begin
                        state      <= SEND;
                        shift_reg  <= sample_ext >> 8;
                        tx_data_o  <= sample_ext[7:0];
                        tx_valid_o <= 1'b1;
                        byte_idx   <= '0;
                    end
                end

                SEND: begin
                    if (tx_hs) begin
`ifdef STREAMER_CHECKSUM_EN
                        csum <= csum + tx_data_o;
`endif
                        if (!last_byte) begin
                            byte_idx  <= byte_idx + 1'b1;
                            tx_data_o <= shift_reg[7:0];
                            shift_reg <= shift_reg >> 8;
                        end else if (!last_sample) begin
                            sample_count_o <= sample_count_o + 1'b1;
                            state          <= FETCH;
                            tx_valid_o     <= 1'b0;
                        end else begin
`ifdef STREAMER_CHECKSUM_EN
                            sample_count_o <= sample_count_o + 1'b1;
                            state          <= CSUM;
                            tx_data_o      <= csum + tx_data_o;
`else
                            sample_count_o <= '0;
                            state          <= IDLE;
                            tx_valid_o     <= 1'b0;
                            frame_count_o  <= frame_count_o + 16'd1;
`endif
                        end
                    end
                end

`ifdef STREAMER_CHECKSUM_EN
                CSUM: begin
                    if (tx_hs) begin
                        sample_count_o <= '0;
                        state          <= IDLE;
                        tx_valid_o     <= 1'b0;
                        frame_count_o  <= frame_count_o + 16'd1;
                    end
                end
`endif

                default: begin
                    state      <= IDLE;
                    tx_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_frame_streamer.sv
// Scoreboard bench for pingpong_frame_streamer (DEPTH=4, WIDTH=36): a byte-level frame model fills a queue, a monitor pops it.
// Define STREAMER_CHECKSUM_EN for both files to check the trailing checksum byte.
module tb_pingpong_frame_streamer;

    localparam int WIDTH      = 36;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BPS        = (WIDTH + 7) / 8;
    localparam int STALL_BYTE = 3;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    buffer_ready_i = 1'b0;
    logic signed [WIDTH-1:0] read_data_i = '0;
    logic                    read_valid_i = 1'b0;
    logic                    read_ready_o;
    logic [7:0]              tx_data_o;
    logic                    tx_valid_o;
    logic                    tx_ready_i = 1'b0;
    logic                    busy_o;
    logic [ADDR_WIDTH:0]     sample_count_o;
    logic [15:0]             frame_count_o;
    logic                    frame_dropped_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]              exp_q[$];
    logic signed [WIDTH-1:0] src_q[$];
    logic [7:0]              golden[20];
    logic signed [WIDTH-1:0] dir_samples[4];
    int                      model_fc = 0;

    bit tx_rand = 1'b0;
    bit rv_rand = 1'b0;
    int stall_req = 0;
    int stall_ack = 0;
    int rv_req = 0;
    int rv_ack = 0;
    int fbyte = 0;
    logic [7:0] last_hdr = '0;

    pingpong_frame_streamer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .buffer_ready_i(buffer_ready_i),
        .read_data_i(read_data_i),
        .read_valid_i(read_valid_i),
        .read_ready_o(read_ready_o),
        .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .busy_o(busy_o),
        .sample_count_o(sample_count_o),
        .frame_count_o(frame_count_o),
        .frame_dropped_o(frame_dropped_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic report_fail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: event did not occur (got none, expected one) at %0t", name, $time);
    endtask

    function automatic logic signed [WIDTH-1:0] random_sample();
        logic [63:0] r;
        logic signed [WIDTH-1:0] v;
        r = {$urandom, $urandom};
        v = r[WIDTH-1:0];
        case ($urandom_range(0, 6))
            0: begin v = '1; v[WIDTH-1] = 1'b0; end
            1: begin v = '0; v[WIDTH-1] = 1'b1; end
            2: v = '1;
            3: v = '0;
            default: ;
        endcase
        return v;
    endfunction

    // Reference model: a frame is SYNC, frame number, then each sample as sign-extended bytes LSB first.
    task automatic start_frame(input bit directed);
        logic signed [WIDTH-1:0] s;
        longint wide;
        logic [7:0] b;
        int sum;
        sum = 0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(model_fc));
        if (directed) begin
            for (int i = 0; i < DEPTH; i++) src_q.push_back(dir_samples[i]);
            for (int i = 0; i < 20; i++) exp_q.push_back(golden[i]);
`ifdef STREAMER_CHECKSUM_EN
            exp_q.push_back(8'hF7);
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s = random_sample();
                src_q.push_back(s);
                wide = longint'(s);
                for (int k = 0; k < BPS; k++) begin
                    b = 8'(wide >>> (8 * k));
                    exp_q.push_back(b);
                    sum = sum + int'(b);
                end
            end
`ifdef STREAMER_CHECKSUM_EN
            exp_q.push_back(8'(sum % 256));
`endif
        end
        @(negedge clk);
        buffer_ready_i = 1'b1;
        @(negedge clk);
        buffer_ready_i = 1'b0;
    endtask

    task automatic finish_frame(input bit drop_final);
        bit done;
        bit dropped_sent;
        done = 1'b0;
        dropped_sent = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            #1;
            if (drop_final && !dropped_sent && busy_o && tx_valid_o && tx_ready_i && exp_q.size() == 0) begin
                buffer_ready_i = 1'b1;
                dropped_sent = 1'b1;
                @(negedge clk);
                #1;
                buffer_ready_i = 1'b0;
                check_output("drop_final_pulse", 64'(frame_dropped_o), 64'd1);
                check_output("drop_final_no_restart", 64'(busy_o), 64'd0);
            end
            if (!busy_o) done = 1'b1;
        end
        if (!done) report_fail("frame_timeout");
        if (drop_final && !dropped_sent) report_fail("drop_final_window");
        model_fc++;
        check_output("frame_count", 64'(frame_count_o), 64'(16'(model_fc)));
        check_output("sample_count_idle", 64'(sample_count_o), 64'd0);
        check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check_output("source_drained", 64'(src_q.size()), 64'd0);
        if (drop_final) begin
            @(negedge clk);
            #1;
            check_output("drop_final_one_cycle", 64'({frame_dropped_o, busy_o}), 64'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        src_q.delete();
        model_fc = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_i = 1'b0;
    endtask

    task automatic apply_stimulus();
        bit ok;
        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            buffer_ready_i = 1'($urandom_range(0, 1));
            #1;
            check_output("reset_outputs",
                64'({tx_valid_o, tx_data_o, read_ready_o, busy_o, sample_count_o, frame_count_o, frame_dropped_o}),
                64'd0);
        end
        buffer_ready_i = 1'b0;
        @(posedge clk);
        #2;
        rst_i = 1'b0;

        // Reset asserted in the middle of a sample.
        start_frame(1'b0);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (fbyte >= 3 && tx_valid_o) ok = 1'b1;
        end
        if (!ok) report_fail("reach_send");
        #1;
        rst_i = 1'b1;
        #1;
        check_output("async_reset_tx_valid", 64'(tx_valid_o), 64'd0);
        check_output("async_reset_busy", 64'(busy_o), 64'd0);
        exp_q.delete();
        src_q.delete();
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_output("idle_after_reset", 64'({tx_valid_o, read_ready_o, busy_o, frame_count_o, sample_count_o}), 64'd0);

        // Directed frame, back-to-back transfer.
        start_frame(1'b1);
        finish_frame(1'b0);
        check_output("frame_count_first", 64'(frame_count_o), 64'd1);

        // Backpressure on the second byte of the first sample.
        stall_req++;
        start_frame(1'b1);
        finish_frame(1'b0);
        check_output("tx_stall_taken", 64'(stall_ack), 64'(stall_req));

        // Input stall in FETCH.
        rv_req++;
        start_frame(1'b0);
        finish_frame(1'b0);
        check_output("rv_stall_taken", 64'(rv_ack), 64'(rv_req));

        // Start request while a frame is mid-SEND.
        tx_rand = 1'b1;
        rv_rand = 1'b1;
        start_frame(1'b0);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (fbyte >= 4 && tx_valid_o) ok = 1'b1;
        end
        if (!ok) report_fail("reach_mid_send");
        buffer_ready_i = 1'b1;
        @(negedge clk);
        #1;
        buffer_ready_i = 1'b0;
        check_output("drop_mid_pulse", 64'(frame_dropped_o), 64'd1);
        @(negedge clk);
        #1;
        check_output("drop_mid_one_cycle", 64'({frame_dropped_o, busy_o}), 64'd1);
        finish_frame(1'b0);

        // Start request on the very cycle of the final handshake.
        tx_rand = 1'b0;
        start_frame(1'b0);
        finish_frame(1'b1);

        // Frame counter wrap through the 8-bit header field.
        apply_reset();
        tx_rand = 1'b1;
        rv_rand = 1'b1;
        for (int i = 0; i < 258; i++) begin
            start_frame(1'b0);
            finish_frame(1'b0);
            if (i == 256) begin
                check_output("wrap_hdr_256", 64'(last_hdr), 64'h00);
                check_output("wrap_frame_count", 64'(frame_count_o), 64'd257);
            end
            if (i == 257) check_output("wrap_hdr_257", 64'(last_hdr), 64'h01);
        end
    endtask

    // Sample source: presents queued samples, optionally with random or directed valid gaps.
    int  rv_hold = 0;
    bit  release_next = 1'b0;
    bit  cap_check = 1'b0;
    always @(negedge clk) begin
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (rst_i) begin
            read_valid_i = 1'($urandom_range(0, 1));
            read_data_i = r[WIDTH-1:0];
            rv_hold = 0;
            release_next = 1'b0;
            cap_check = 1'b0;
        end else begin
            if (cap_check) begin
                check_output("capture_on_first_valid", 64'(read_ready_o), 64'd0);
                cap_check = 1'b0;
            end
            if (rv_hold == 0 && rv_req != rv_ack && read_ready_o) begin
                rv_ack = rv_req;
                rv_hold = 5;
            end
            if (rv_hold > 0) begin
                check_output("fetch_stall_state", 64'({read_ready_o, tx_valid_o}), 64'b10);
                read_valid_i = 1'b0;
                read_data_i = r[WIDTH-1:0];
                rv_hold--;
                if (rv_hold == 0) release_next = 1'b1;
            end else if (src_q.size() > 0 && (release_next || !rv_rand || $urandom_range(0, 2) != 0)) begin
                if (release_next) begin
                    cap_check = 1'b1;
                    release_next = 1'b0;
                end
                read_valid_i = 1'b1;
                read_data_i = src_q[0];
            end else begin
                read_valid_i = 1'b0;
                read_data_i = r[WIDTH-1:0];
            end
            if (read_valid_i && read_ready_o) void'(src_q.pop_front());
        end
    end

    // Monitor: drives tx_ready, checks protocol stability and pops the scoreboard on every byte handshake.
    int         tx_hold = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        logic [7:0] expected;
        if (rst_i) begin
            tx_ready_i = 1'($urandom_range(0, 1));
            fbyte = 0;
            tx_hold = 0;
            prev_stall = 1'b0;
        end else begin
            if (!busy_o) fbyte = 0;
            if (tx_hold == 0 && stall_req != stall_ack && tx_valid_o && fbyte == STALL_BYTE) begin
                stall_ack = stall_req;
                tx_hold = 10;
            end
            if (tx_hold > 0) begin
                tx_ready_i = 1'b0;
                tx_hold--;
                check_output("stall_tx_valid", 64'(tx_valid_o), 64'd1);
                check_output("stall_tx_data", 64'(tx_data_o), 64'h00);
                check_output("stall_read_ready", 64'(read_ready_o), 64'd0);
            end else begin
                tx_ready_i = tx_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (prev_stall) begin
                check_output("hold_tx_valid", 64'(tx_valid_o), 64'd1);
                check_output("hold_tx_data", 64'(tx_data_o), 64'(prev_data));
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data = tx_data_o;
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL tx_extra_byte: got %0h, expected no byte at %0t", tx_data_o, $time);
                end else begin
                    expected = exp_q.pop_front();
                    check_output("tx_byte", 64'(tx_data_o), 64'(expected));
                end
                if (fbyte == 1) last_hdr = tx_data_o;
                fbyte++;
            end
        end
    end

    initial begin
        golden = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'hF8};
        dir_samples = '{36'sd1, -36'sd1, 36'sh7FFFFFFFF, 36'sh800000000};
        $display("[TB] starting pingpong_frame_streamer bench");
        apply_stimulus();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
